conv3x3_stream_array: RTL and testbench

CONV3X3_STREAM_ARRAY -- requirements
Module: conv3x3_stream_array

---
 rtl/conv3x3_stream_array.sv | 247 ++++++++++++++++++++++++
 tb/tb_conv3x3_stream_array.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream_array.sv
// Streaming 3x3 convolution over a W x H 8-bit raster frame, NOCH output channels.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   start             - frame start pulse (taken in IDLE only)
//   in_vld/in_data    - pixel stream input, accepted when in_vld & in_rdy
//   in_rdy            - high while the frame body is being received
//   win               - NOCH x 9 signed 8-bit taps, channel k tap t at [k*72+t*8 +: 8]
//   cfg_shift/relu    - requantisation shift and output range, captured at start
//   out_vld           - one output pixel (all channels) valid
//   out_acc/out_data  - full signed sums / requantised 8-bit results per channel
//   busy, frame_done  - frame in progress, pulse with the last output
module conv3x3_stream_array #(
  parameter int unsigned W     = 256,
  parameter int unsigned H     = 256,
  parameter int unsigned NOCH  = 4,
  parameter int unsigned ACC_W = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_vld,
  input  logic [7:0]              in_data,
  output logic                    in_rdy,
  input  logic [NOCH*72-1:0]      win,
  input  logic [4:0]              cfg_shift,
  input  logic                    cfg_relu,
  output logic                    out_vld,
  output logic [NOCH*ACC_W-1:0]   out_acc,
  output logic [NOCH*8-1:0]       out_data,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned NPIX   = W * H;
  localparam int unsigned NSHIFT = NPIX + W + 1;
  localparam int unsigned CNT_W  = $clog2(NSHIFT + 1);
  localparam int unsigned COL_W  = $clog2(W);
  localparam int unsigned ROW_W  = $clog2(H);

  localparam logic signed [ACC_W-1:0] SAT_HI_U = ACC_W'(255);
  localparam logic signed [ACC_W-1:0] SAT_HI_S = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO_S = ACC_W'(-128);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;

  state_e state_q, state_d;
  logic   in_rdy_q, in_rdy_d, busy_q, busy_d;
  logic   start_acc_c, adv_c;
  logic [7:0] pix_c;

  logic [CNT_W-1:0] cnt_q;
  logic [COL_W-1:0] col_q, ocol_q;
  logic [ROW_W-1:0] orow_q;
  logic [4:0]       cfg_shift_q;
  logic             cfg_relu_q;

  logic [7:0] lb1_q [W];
  logic [7:0] lb2_q [W];
  logic [7:0] win_q [3][3];
  logic       wv_q;

  logic                    row_ok_c [3];
  logic                    col_ok_c [3];
  logic signed [16:0]      px17_c   [3][3];
  logic signed [16:0]      wt17_c   [NOCH][9];
  logic signed [16:0]      prod_c   [NOCH][9];
  logic signed [16:0]      prod_q   [NOCH][9];
  logic                    s1_vld_q, s1_last_q;
  logic signed [ACC_W-1:0] sum_c    [NOCH];
  logic signed [ACC_W-1:0] sh_c     [NOCH];
  logic [7:0]              q_c      [NOCH];

  logic                    out_vld_q, frame_done_q;
  logic [NOCH*ACC_W-1:0]   out_acc_q;
  logic [NOCH*8-1:0]       out_data_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      in_rdy_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_rdy_q <= in_rdy_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic; FLUSH waits for the last output to leave the pipeline
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (in_vld && cnt_q == CNT_W'(NPIX - 1)) state_d = S_FLUSH;
      S_FLUSH: if (frame_done_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / control decode; flush injects zero pixels until every window is formed
  always_comb begin
    in_rdy_d    = (state_d == S_RUN);
    busy_d      = (state_d != S_IDLE);
    start_acc_c = (state_q == S_IDLE) && start;
    adv_c       = ((state_q == S_RUN) && in_vld) ||
                  ((state_q == S_FLUSH) && (cnt_q < CNT_W'(NSHIFT)));
    pix_c       = (state_q == S_RUN) ? in_data : 8'd0;
  end

  // Shift counters and captured configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      col_q       <= '0;
      cfg_shift_q <= '0;
      cfg_relu_q  <= 1'b0;
    end else if (start_acc_c) begin
      cnt_q       <= '0;
      col_q       <= '0;
      cfg_shift_q <= cfg_shift;
      cfg_relu_q  <= cfg_relu;
    end else if (adv_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
      col_q <= (col_q == COL_W'(W - 1)) ? '0 : col_q + COL_W'(1);
    end
  end

  // Line buffers: lb1 yields the pixel one row up, lb2 two rows up
  always_ff @(posedge clk) begin
    if (adv_c) begin
      lb1_q[col_q] <= pix_c;
      lb2_q[col_q] <= lb1_q[col_q];
    end
  end

  // 3x3 window; centre lags the newest pixel by W+1 positions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wv_q <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
    end else begin
      wv_q <= adv_c && (cnt_q >= CNT_W'(W + 1));
      if (adv_c) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb2_q[col_q];
        win_q[1][2] <= lb1_q[col_q];
        win_q[2][2] <= pix_c;
      end
    end
  end

  // Zero padding masks any tap outside the frame, including wrapped or stale data
  always_comb begin
    row_ok_c[0] = (orow_q != '0);
    row_ok_c[1] = 1'b1;
    row_ok_c[2] = (orow_q != ROW_W'(H - 1));
    col_ok_c[0] = (ocol_q != '0);
    col_ok_c[1] = 1'b1;
    col_ok_c[2] = (ocol_q != COL_W'(W - 1));
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        px17_c[r][c] = (row_ok_c[r] && col_ok_c[c]) ? {9'd0, win_q[r][c]} : '0;
    for (int k = 0; k < NOCH; k++) begin
      for (int t = 0; t < 9; t++) begin
        wt17_c[k][t] = {{9{win[k*72 + t*8 + 7]}}, win[k*72 + t*8 +: 8]};
        prod_c[k][t] = px17_c[t/3][t%3] * wt17_c[k][t];
      end
    end
  end

  // Stage 1: products plus output-position tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      orow_q    <= '0;
      ocol_q    <= '0;
      for (int k = 0; k < NOCH; k++)
        for (int t = 0; t < 9; t++) prod_q[k][t] <= '0;
    end else begin
      s1_vld_q  <= wv_q;
      s1_last_q <= wv_q && (orow_q == ROW_W'(H - 1)) && (ocol_q == COL_W'(W - 1));
      if (start_acc_c) begin
        orow_q <= '0;
        ocol_q <= '0;
      end else if (wv_q) begin
        prod_q <= prod_c;
        if (ocol_q == COL_W'(W - 1)) begin
          ocol_q <= '0;
          orow_q <= (orow_q == ROW_W'(H - 1)) ? '0 : orow_q + ROW_W'(1);
        end else begin
          ocol_q <= ocol_q + COL_W'(1);
        end
      end
    end
  end

  // Adder tree and requantisation
  always_comb begin
    for (int k = 0; k < NOCH; k++) begin
      sum_c[k] = '0;
      for (int t = 0; t < 9; t++) sum_c[k] = sum_c[k] + ACC_W'(prod_q[k][t]);
      sh_c[k] = sum_c[k] >>> cfg_shift_q;
      if (cfg_relu_q) begin
        if (sh_c[k] < 0)             q_c[k] = 8'd0;
        else if (sh_c[k] > SAT_HI_U) q_c[k] = 8'd255;
        else                         q_c[k] = sh_c[k][7:0];
      end else begin
        if (sh_c[k] < SAT_LO_S)      q_c[k] = 8'h80;
        else if (sh_c[k] > SAT_HI_S) q_c[k] = 8'h7f;
        else                         q_c[k] = sh_c[k][7:0];
      end
    end
  end

  // Stage 2: registered outputs, held while no new result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
      out_acc_q    <= '0;
      out_data_q   <= '0;
    end else begin
      out_vld_q    <= s1_vld_q;
      frame_done_q <= s1_vld_q && s1_last_q;
      if (s1_vld_q) begin
        for (int k = 0; k < NOCH; k++) begin
          out_acc_q[k*ACC_W +: ACC_W] <= sum_c[k];
          out_data_q[k*8 +: 8]        <= q_c[k];
        end
      end
    end
  end

  assign in_rdy     = in_rdy_q;
  assign busy       = busy_q;
  assign out_vld    = out_vld_q;
  assign frame_done = frame_done_q;
  assign out_acc    = out_acc_q;
  assign out_data   = out_data_q;

endmodule

// File: tb/tb_conv3x3_stream_array.sv
// Scoreboard bench for conv3x3_stream_array on a 4x4 frame with 4 channels.
module tb_conv3x3_stream_array;
  localparam int W = 4, H = 4, NOCH = 4, ACC_W = 21, NPIX = W * H;
  localparam int AW = NOCH * ACC_W, DW = NOCH * 8;

  logic clk = 1'b0;
  logic rst, start, in_vld, in_rdy, cfg_relu, out_vld, busy, frame_done;
  logic [7:0]         in_data;
  logic [NOCH*72-1:0] win;
  logic [4:0]         cfg_shift;
  logic [AW-1:0]      out_acc;
  logic [DW-1:0]      out_data;

  conv3x3_stream_array #(.W(W), .H(H), .NOCH(NOCH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_vld(in_vld), .in_data(in_data),
    .in_rdy(in_rdy), .win(win), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .out_vld(out_vld), .out_acc(out_acc), .out_data(out_data), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] acc;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_tests = 0, n_fail = 0;
  int            pix [NPIX];
  logic [AW-1:0] rec_acc [NPIX];
  logic [AW-1:0] ref_a   [NPIX];
  logic [AW-1:0] ref_r   [NPIX];
  int            out_idx = 0;
  bit            ignore_out = 1'b0;
  int            n_ignored = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pop and compare each result against the model
  always @(negedge clk) begin
    if (!rst) begin
      if (out_vld) begin
        if (ignore_out) n_ignored++;
        else if (exp_q.size() == 0) check("unexpected_out_vld", out_vld, 1'b0);
        else begin
          mon_e = exp_q.pop_front();
          check($sformatf("acc[%0d]", out_idx), out_acc, mon_e.acc);
          check($sformatf("data[%0d]", out_idx), out_data, mon_e.data);
          check($sformatf("done[%0d]", out_idx), frame_done, mon_e.last);
          if (out_idx < NPIX) rec_acc[out_idx] = out_acc;
          out_idx++;
        end
      end else if (frame_done) begin
        check("done_without_vld", frame_done, 1'b0);
      end
    end
  end

  task automatic set_w(input int k, input int val);
    for (int t = 0; t < 9; t++) win[k*72 + t*8 +: 8] = 8'(val);
  endtask

  // Reference convolution with zero padding and requantisation
  task automatic push_expected();
    exp_t e;
    int acc, s, rr, cc, wt;
    logic signed [7:0] w8;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e.acc = '0; e.data = '0;
        for (int k = 0; k < NOCH; k++) begin
          acc = 0;
          for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
              rr = r + dy; cc = c + dx;
              if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                w8  = win[k*72 + ((dy+1)*3 + (dx+1))*8 +: 8];
                wt  = int'(w8);
                acc += pix[rr*W + cc] * wt;
              end
            end
          end
          s = acc >>> cfg_shift;
          if (cfg_relu) s = (s < 0) ? 0 : (s > 255) ? 255 : s;
          else          s = (s < -128) ? -128 : (s > 127) ? 127 : s;
          e.acc[k*ACC_W +: ACC_W] = ACC_W'(acc);
          e.data[k*8 +: 8]        = 8'(s);
        end
        e.last = (r == H-1) && (c == W-1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_frame(input bit gaps, input int abort_at);
    bit accepted;
    int guard;
    out_idx = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      if (i == abort_at) return;
      accepted = 1'b0;
      guard = 0;
      while (!accepted) begin
        in_vld = 1'b1; in_data = 8'(pix[i]);
        @(negedge clk); accepted = in_rdy;
        @(posedge clk); #1;
        guard++;
        if (!accepted && guard > 50) begin
          check("in_rdy_timeout", accepted, 1'b1);
          in_vld = 1'b0;
          return;
        end
      end
      in_vld = 1'b0;
      if (gaps) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_frame_end();
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    check("frame_timeout", k < 500, 1'b1);
    check("outputs_left", exp_q.size(), 0);
    check("out_count", out_idx, NPIX);
  endtask

  task automatic full_frame(input bit gaps);
    push_expected();
    run_frame(gaps, -1);
    wait_frame_end();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_vld = 1'b0; in_data = '0;
    win = '0; cfg_shift = '0; cfg_relu = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_acc", out_acc, 0);
    check("rst_data", out_data, 0);
    @(posedge clk); #1 rst = 1'b0;

    // All ones, all weights one
    for (int i = 0; i < NPIX; i++) pix[i] = 1;
    for (int k = 0; k < NOCH; k++) set_w(k, 1);
    full_frame(1'b0);
    ref_a = rec_acc;
    check("ones_corner", rec_acc[0][ACC_W-1:0], 21'd4);
    check("ones_edge", rec_acc[1][ACC_W-1:0], 21'd6);
    check("ones_inner", rec_acc[5][ACC_W-1:0], 21'd9);

    // Single impulse, channel 0 taps 1..9
    for (int i = 0; i < NPIX; i++) pix[i] = 0;
    pix[5] = 100;
    win = '0;
    for (int t = 0; t < 9; t++) win[t*8 +: 8] = 8'(t + 1);
    full_frame(1'b0);
    check("imp_00", rec_acc[0][ACC_W-1:0], 21'd900);
    check("imp_11", rec_acc[5][ACC_W-1:0], 21'd500);
    check("imp_22", rec_acc[10][ACC_W-1:0], 21'd100);
    check("imp_33", rec_acc[15][ACC_W-1:0], 21'd0);

    // Saturation corners
    for (int i = 0; i < NPIX; i++) pix[i] = 255;
    for (int k = 0; k < NOCH; k++) set_w(k, 127);
    cfg_relu = 1'b1; full_frame(1'b0);
    check("sat_acc_inner", rec_acc[5][ACC_W-1:0], 21'd291465);
    cfg_relu = 1'b0; full_frame(1'b0);
    for (int k = 0; k < NOCH; k++) set_w(k, -128);
    cfg_relu = 1'b1; full_frame(1'b0);
    cfg_relu = 1'b0; full_frame(1'b0);

    // Random frame, gap-free then with in_vld toggling
    for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(0, 255));
    for (int k = 0; k < NOCH; k++)
      for (int t = 0; t < 9; t++) win[k*72 + t*8 +: 8] = 8'($urandom_range(0, 255));
    cfg_shift = 5'd4; cfg_relu = 1'b0;
    full_frame(1'b0);
    ref_r = rec_acc;
    full_frame(1'b1);
    for (int i = 0; i < NPIX; i++) check($sformatf("gap_seq[%0d]", i), rec_acc[i], ref_r[i]);

    // Reset mid-frame, then a clean ones frame
    for (int i = 0; i < NPIX; i++) pix[i] = 1;
    for (int k = 0; k < NOCH; k++) set_w(k, 1);
    cfg_shift = 5'd0;
    ignore_out = 1'b1;
    run_frame(1'b0, 7);
    rst = 1'b1; in_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; ignore_out = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_out_vld", out_vld, 0);
    check("abort_busy", busy, 0);
    check("abort_acc", out_acc, 0);
    full_frame(1'b0);
    for (int i = 0; i < NPIX; i++) check($sformatf("post_abort[%0d]", i), rec_acc[i], ref_a[i]);

    // Per-channel weights 1, 2, -1, 0 on random pixels
    for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(0, 255));
    set_w(0, 1); set_w(1, 2); set_w(2, -1); set_w(3, 0);
    full_frame(1'b0);

    // Random weights, relu with a larger shift
    for (int k = 0; k < NOCH; k++)
      for (int t = 0; t < 9; t++) win[k*72 + t*8 +: 8] = 8'($urandom_range(0, 255));
    cfg_shift = 5'd6; cfg_relu = 1'b1;
    full_frame(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
